// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: a processor port (P) and a loader/debug port (D)
// share one single-ported dmem through round-robin grants and locked D bursts.
//
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-low reset
//   p_req/p_wren/p_addr/p_wdata -> p_gnt/p_rvalid/p_rdata : processor port
//   d_req/d_lock/d_wren/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata : loader port
//   mem_addr/mem_data/mem_wren -> dmem, mem_q <- dmem (1-cycle read latency)
//   owner                 - FSM state (00 idle, 01 P, 10 D, 11 D burst)
module dmem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_wren,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_rdata,
  input  logic              d_req,
  input  logic              d_lock,
  input  logic              d_wren,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [1:0]        owner
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_P     = 2'b01,
    S_D     = 2'b10,
    S_BURST = 2'b11
  } state_t;

  state_t          state, state_nxt;
  logic            last_d, last_d_nxt;
  logic [CW-1:0]   burst_cnt, cnt_nxt, cnt_inc;
  logic            p_rv_q, d_rv_q;
  logic [DATA_W-1:0] p_hold, d_hold;

  assign cnt_inc = burst_cnt + 1'b1;

  always_comb begin
    p_gnt      = 1'b0;
    d_gnt      = 1'b0;
    state_nxt  = S_IDLE;
    last_d_nxt = last_d;
    cnt_nxt    = '0;
    // grants are suppressed for the whole reset cycle
    if (reset) begin
      if (state == S_BURST && d_req && d_lock) begin
        d_gnt = 1'b1;
      end else if (p_req && d_req) begin
        p_gnt = last_d;
        d_gnt = !last_d;
      end else begin
        p_gnt = p_req;
        d_gnt = d_req;
      end
    end
    unique case (1'b1)
      p_gnt: begin
        state_nxt  = S_P;
        last_d_nxt = 1'b0;
      end
      d_gnt: begin
        last_d_nxt = 1'b1;
        if (!d_lock) begin
          state_nxt = S_D;
        end else if (state != S_BURST) begin
          // the entry grant is the first beat of the burst
          state_nxt = S_BURST;
        end else if (cnt_inc == LAST) begin
          // burst exhausted: drop to D so round robin favours P next
          state_nxt = S_D;
        end else begin
          state_nxt = S_BURST;
          cnt_nxt   = cnt_inc;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    mem_wren = 1'b0;
    unique case (1'b1)
      p_gnt: begin
        mem_addr = p_addr;
        mem_data = p_wdata;
        mem_wren = p_wren;
      end
      d_gnt: begin
        mem_addr = d_addr;
        mem_data = d_wdata;
        mem_wren = d_wren;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      last_d    <= 1'b1;
      burst_cnt <= '0;
      p_rv_q    <= 1'b0;
      d_rv_q    <= 1'b0;
      p_hold    <= '0;
      d_hold    <= '0;
    end else begin
      state     <= state_nxt;
      last_d    <= last_d_nxt;
      burst_cnt <= cnt_nxt;
      p_rv_q    <= p_gnt && !p_wren;
      d_rv_q    <= d_gnt && !d_wren;
      if (p_rv_q) p_hold <= mem_q;
      if (d_rv_q) d_hold <= mem_q;
    end
  end

  // an asserted reset cancels a read completing in that cycle
  assign p_rvalid = p_rv_q && reset;
  assign d_rvalid = d_rv_q && reset;
  assign p_rdata  = p_rvalid ? mem_q : p_hold;
  assign d_rdata  = d_rvalid ? mem_q : d_hold;
  assign owner    = state;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, the memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, the memory data width.
REQ-003 SHALL have parameter MAX_BURST, default 16, the maximum number of consecutive locked grants to the D port.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset; low on a rising clock edge resets all state.
REQ-006 SHALL have ports p_req, p_wren, input, 1 bit each: processor access request and write enable.
REQ-007 SHALL have ports p_addr, input, ADDR_W bits, and p_wdata, input, DATA_W bits: processor address and write data.
REQ-008 SHALL have ports p_gnt, output, 1 bit, and p_rvalid, output, 1 bit: processor grant and read-data valid.
REQ-009 SHALL have port p_rdata, output, DATA_W bits: processor read data.
REQ-010 SHALL have ports d_req, d_lock, d_wren, input, 1 bit each: loader/debug request, burst lock and write enable.
REQ-011 SHALL have ports d_addr, input, ADDR_W bits, and d_wdata, input, DATA_W bits: loader address and write data.
REQ-012 SHALL have ports d_gnt, d_rvalid, output, 1 bit each, and d_rdata, output, DATA_W bits: loader grant, read valid and read data.
REQ-013 SHALL have ports mem_addr, output, ADDR_W bits; mem_data, output, DATA_W bits; and mem_wren, output, 1 bit: the dmem port.
REQ-014 SHALL have port mem_q, input, DATA_W bits: dmem read data, valid one cycle after the address.
REQ-015 SHALL have port owner, output, 2 bits: current FSM state (00 IDLE, 01 P, 10 D, 11 D_BURST).

Function
REQ-016 SHALL issue at most one grant per cycle; p_gnt and d_gnt are never high together.
REQ-017 SHALL compute grants combinationally from the current state, the requests and last_owner, in the same cycle as the requests.
REQ-018 SHALL drive mem_addr, mem_data and mem_wren from the granted port's addr, wdata and wren.
REQ-019 SHALL drive mem_wren = 0 and mem_addr = 0 when no grant is issued.
REQ-020 SHALL resolve simultaneous p_req and d_req outside D_BURST by round robin: the port not matching last_owner wins.
REQ-021 SHALL grant a sole requester immediately, regardless of last_owner.
REQ-022 SHALL update last_owner to the granted port on every grant.
REQ-023 SHALL have FSM transitions: a P grant goes to P; a D grant with d_lock = 0 goes to D; a D grant with d_lock = 1 goes to D_BURST.
REQ-024 SHALL, with no grant, go to IDLE.
REQ-025 SHALL, in D_BURST, give the D port absolute priority while d_req = 1 and d_lock = 1.
REQ-026 SHALL keep burst_cnt, incremented on each D grant in D_BURST and cleared on leaving D_BURST.
REQ-027 SHALL, when burst_cnt reaches MAX_BURST-1 on a grant, leave D_BURST and give the next grant to P if p_req = 1.
REQ-028 SHALL leave D_BURST via round-robin rules when d_req or d_lock drops.
REQ-029 SHALL register a read (granted with wren = 0) so that the port's rvalid is high the following cycle, for exactly one cycle per granted read.
REQ-030 SHALL drive the port's rdata = mem_q during that rvalid cycle, and hold rdata at its last value otherwise.
REQ-031 SHALL produce no rvalid for writes.
REQ-032 SHALL give read latency 1 cycle and write completion at the grant edge; back-to-back grants are permitted every cycle.
REQ-033 SHALL let a requester keep req high until it sees gnt; a dropped req withdraws the request without error.

Reset
REQ-034 SHALL, when reset is low on a rising edge, force state to IDLE, last_owner to D (P wins the first tie), burst_cnt to 0, p_rvalid and d_rvalid to 0, and p_rdata and d_rdata to 0.
REQ-035 SHALL hold p_gnt, d_gnt and mem_wren at 0 while reset is low.
REQ-036 SHALL cancel a reset mid-burst or mid-read: no pending rvalid after reset.

Verification
REQ-037 SHALL cover: after reset, p_req = d_req = 1 for 4 cycles -> grants alternate P, D, P, D.
REQ-038 SHALL cover: P read at addr 0x010 with mem_q = 0xDEADBEEF the next cycle -> p_rvalid = 1 with p_rdata = 0xDEADBEEF one cycle after p_gnt, and d_rvalid stays 0.
REQ-039 SHALL cover: d_lock = 1 with both requesting continuously -> exactly 16 consecutive d_gnt cycles, then a p_gnt cycle, with owner = 11 during the burst.
REQ-040 SHALL cover: D write 0x12345678 to 0x0FF -> mem_wren = 1, mem_addr = 0x0FF and mem_data = 0x12345678 in the grant cycle, and no rvalid.
REQ-041 SHALL cover: reset driven low in the cycle after a granted read -> p_rvalid stays 0, owner = 00 and both grants are 0.
REQ-042 SHALL cover: no requests -> mem_wren = 0 and owner = 00 every cycle.
